// File: rtl/au_result_checker_if.sv
// ============================================================================
// Module   : au_result_checker_if
// Brief    : Vector handshake, arithmetic-unit drive/return and status bundle
//            for au_result_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface au_result_checker_if;
  // Vector offer handshake
  logic        vec_valid;
  logic        vec_ready;
  logic [2:0]  vec_mode;
  logic [3:0]  vec_a;
  logic [3:0]  vec_b;
  // Arithmetic unit drive and return
  logic [2:0]  drv_mode;
  logic [3:0]  drv_a;
  logic [3:0]  drv_b;
  logic [4:0]  au_d;
  // Status
  logic [11:0] vec_count;
  logic [11:0] err_count;
  logic        first_err_valid;
  logic [20:0] first_err_info;
  logic        done;
  logic        pass;

  // Stimulus side: offers vectors, returns the AU result, observes status
  modport master (
    output vec_valid, vec_mode, vec_a, vec_b, au_d,
    input  vec_ready, drv_mode, drv_a, drv_b,
    input  vec_count, err_count, first_err_valid, first_err_info, done, pass
  );

  // Checker side
  modport slave (
    input  vec_valid, vec_mode, vec_a, vec_b, au_d,
    output vec_ready, drv_mode, drv_a, drv_b,
    output vec_count, err_count, first_err_valid, first_err_info, done, pass
  );
endinterface

`default_nettype wire

// File: rtl/au_result_checker.sv
// ============================================================================
// Module   : au_result_checker
// Brief    : Accepts {mode,a,b} vectors, drives them to an arithmetic unit,
//            waits for it to settle, compares its result against a reference
//            and keeps vector/error counts plus a first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module au_result_checker #(
  parameter int SETTLE_CYCLES = 2,    // cycles allowed for the AU to settle before sampling (1..15)
  parameter int NUM_VECTORS   = 2048  // vectors checked before done is reported (1..4095)
) (
  input  wire                 clk,
  input  wire                 rst,
  au_result_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [11:0] VEC_TOTAL   = 12'(NUM_VECTORS);
  localparam logic [11:0] COUNT_MAX   = 12'hFFF;

  state_t      state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [2:0]  drv_mode_q, drv_mode_d;
  logic [3:0]  drv_a_q, drv_a_d;
  logic [3:0]  drv_b_q, drv_b_d;
  logic [11:0] vec_count_q, vec_count_d;
  logic [11:0] err_count_q, err_count_d;
  logic        first_err_valid_q, first_err_valid_d;
  logic [20:0] first_err_info_q, first_err_info_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [4:0]  a_ext;
  logic [4:0]  b_ext;
  logic [4:0]  nb_ext;
  logic [4:0]  expected;
  logic        mismatch;

  // Reference result for the vector currently driven; all sums wrap at 5 bits
  always_comb begin
    a_ext  = {1'b0, drv_a_q};
    b_ext  = {1'b0, drv_b_q};
    nb_ext = {1'b0, ~drv_b_q};
    case (drv_mode_q)
      3'd0:    expected = a_ext + b_ext;
      3'd1:    expected = a_ext + b_ext + 5'd1;
      3'd2:    expected = a_ext + nb_ext;
      3'd3:    expected = a_ext + nb_ext + 5'd1;
      3'd4:    expected = a_ext;
      3'd5:    expected = a_ext + 5'd1;
      3'd6:    expected = a_ext + 5'd15;
      default: expected = {1'b1, drv_a_q};
    endcase
  end

  // Sequencing: accept in IDLE, count down in SETTLE, compare leaving CHECK,
  // DONE is terminal and freezes everything until reset
  always_comb begin
    state_d           = state_q;
    settle_cnt_d      = settle_cnt_q;
    drv_mode_d        = drv_mode_q;
    drv_a_d           = drv_a_q;
    drv_b_d           = drv_b_q;
    vec_count_d       = vec_count_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_info_d  = first_err_info_q;
    mismatch          = (bus.au_d != expected);

    case (state_q)
      ST_IDLE: begin
        if (bus.vec_valid) begin
          drv_mode_d   = bus.vec_mode;
          drv_a_d      = bus.vec_a;
          drv_b_d      = bus.vec_b;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q - 4'd1;
        // Last settle cycle is the one that sees a count of 1
        if (settle_cnt_q <= 4'd1) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        vec_count_d = vec_count_q + 12'd1;
        if (mismatch) begin
          if (err_count_q != COUNT_MAX) begin
            err_count_d = err_count_q + 12'd1;
          end
          // Only the first mismatch is kept; later ones leave it untouched
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_info_d  = {drv_mode_q, drv_a_q, drv_b_q, expected, bus.au_d};
          end
        end
        state_d = (vec_count_d == VEC_TOTAL) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // done/pass are registered so they rise together on the final compare edge
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_count_d == 12'd0);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      settle_cnt_q      <= 4'd0;
      drv_mode_q        <= 3'd0;
      drv_a_q           <= 4'd0;
      drv_b_q           <= 4'd0;
      vec_count_q       <= 12'd0;
      err_count_q       <= 12'd0;
      first_err_valid_q <= 1'b0;
      first_err_info_q  <= 21'd0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      settle_cnt_q      <= settle_cnt_d;
      drv_mode_q        <= drv_mode_d;
      drv_a_q           <= drv_a_d;
      drv_b_q           <= drv_b_d;
      vec_count_q       <= vec_count_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_info_q  <= first_err_info_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
    end
  end

  // Ready follows IDLE directly, so it is also high while reset holds IDLE
  assign bus.vec_ready       = (state_q == ST_IDLE);
  assign bus.drv_mode        = drv_mode_q;
  assign bus.drv_a           = drv_a_q;
  assign bus.drv_b           = drv_b_q;
  assign bus.vec_count       = vec_count_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_valid = first_err_valid_q;
  assign bus.first_err_info  = first_err_info_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_au_result_checker.sv
// ============================================================================
// Module   : tb_au_result_checker
// Brief    : Directed self-checking bench for au_result_checker. Instance A
//            (SETTLE_CYCLES=2, NUM_VECTORS=2048) covers latency, capture,
//            reset abort, corners and the full sweep; instance B
//            (SETTLE_CYCLES=1, NUM_VECTORS=4) covers back-to-back offers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_au_result_checker;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       force_en;
  logic [4:0] force_val;
  logic [4:0] flip;
  int         tests = 0;
  int         fails = 0;

  au_result_checker_if ifa ();
  au_result_checker_if ifb ();

  au_result_checker #(.SETTLE_CYCLES(2), .NUM_VECTORS(2048)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  au_result_checker #(.SETTLE_CYCLES(1), .NUM_VECTORS(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ideal arithmetic unit, written with integer arithmetic reduced mod 32
  function automatic logic [4:0] au_model(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (m)
      3'd0:    s = int'(a) + int'(b);
      3'd1:    s = int'(a) + int'(b) + 1;
      3'd2:    s = int'(a) + (15 - int'(b));
      3'd3:    s = int'(a) + (15 - int'(b)) + 1;
      3'd4:    s = int'(a);
      3'd5:    s = int'(a) + 1;
      3'd6:    s = int'(a) + 15;
      default: s = 16 + int'(a);
    endcase
    return 5'(s % 32);
  endfunction

  always_comb begin
    ifa.au_d = force_en ? force_val : (au_model(ifa.drv_mode, ifa.drv_a, ifa.drv_b) ^ flip);
    ifb.au_d = au_model(ifb.drv_mode, ifb.drv_a, ifb.drv_b);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Offer one vector on A; called at a negedge, returns one negedge after the handshake
  task automatic send_a(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    while (ifa.vec_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 64) begin fails++; $display("FAIL send_a_ready: vec_ready=%b, required 1 within 64 cycles", ifa.vec_ready); end
    ifa.vec_valid = 1'b1;
    ifa.vec_mode  = m;
    ifa.vec_a     = a;
    ifa.vec_b     = b;
    @(negedge clk);
    ifa.vec_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (ifa.vec_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 64) begin fails++; $display("FAIL wait_idle_a: vec_ready=%b, required 1 within 64 cycles", ifa.vec_ready); end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a         = 1'b1;
    ifa.vec_valid = 1'b0;
    force_en      = 1'b0;
    flip          = 5'd0;
    @(negedge clk);
    rst_a         = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ifa.vec_valid = 1'b1;
    ifa.vec_mode  = 3'd5;
    ifa.vec_a     = 4'h9;
    ifa.vec_b     = 4'h6;
    repeat (3) @(negedge clk);
    tests++; if (ifa.vec_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, want 1", ifa.vec_ready); end
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== 11'd0) begin fails++; $display("FAIL reset_drv: got %h, want 0", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}); end
    tests++; if (ifa.vec_count !== 12'd0) begin fails++; $display("FAIL reset_vec_count: got %0d, want 0", ifa.vec_count); end
    tests++; if (ifa.err_count !== 12'd0) begin fails++; $display("FAIL reset_err_count: got %0d, want 0", ifa.err_count); end
    tests++; if (ifa.first_err_valid !== 1'b0 || ifa.first_err_info !== 21'd0) begin fails++; $display("FAIL reset_capture: got %b/%h, want 0/0", ifa.first_err_valid, ifa.first_err_info); end
    tests++; if (ifa.done !== 1'b0 || ifa.pass !== 1'b0) begin fails++; $display("FAIL reset_done_pass: got %b/%b, want 0/0", ifa.done, ifa.pass); end
    tests++; if (ifb.vec_ready !== 1'b1 || ifb.vec_count !== 12'd0) begin fails++; $display("FAIL reset_b: ready %b count %0d, want 1/0", ifb.vec_ready, ifb.vec_count); end
    ifa.vec_valid = 1'b0;
    rst_a         = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== 11'd0 || ifa.vec_ready !== 1'b1) begin fails++; $display("FAIL idle_no_valid: drv %h ready %b, want 0/1", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}, ifa.vec_ready); end
  endtask

  task automatic test_latency();
    force_en  = 1'b1;
    force_val = 5'b00000;
    send_a(3'd1, 4'hF, 4'h0);
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== {3'd1, 4'hF, 4'h0}) begin fails++; $display("FAIL lat_drv: got %h, want %h", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}, {3'd1, 4'hF, 4'h0}); end
    tests++; if (ifa.vec_ready !== 1'b0) begin fails++; $display("FAIL lat_ready_settle: got %b, want 0", ifa.vec_ready); end
    // New data offered while busy must be ignored
    ifa.vec_valid = 1'b1;
    ifa.vec_mode  = 3'd7;
    ifa.vec_a     = 4'h3;
    ifa.vec_b     = 4'h3;
    @(negedge clk);
    ifa.vec_valid = 1'b0;
    tests++; if (ifa.vec_count !== 12'd0) begin fails++; $display("FAIL lat_count_cyc1: got %0d, want 0", ifa.vec_count); end
    @(negedge clk);
    tests++; if (ifa.vec_count !== 12'd0) begin fails++; $display("FAIL lat_count_cyc2: got %0d, want 0", ifa.vec_count); end
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== {3'd1, 4'hF, 4'h0}) begin fails++; $display("FAIL busy_ignore: drv %h, want %h", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}, {3'd1, 4'hF, 4'h0}); end
    @(negedge clk);
    tests++; if (ifa.vec_count !== 12'd1) begin fails++; $display("FAIL lat_count_cyc3: got %0d, want 1", ifa.vec_count); end
    tests++; if (ifa.err_count !== 12'd1) begin fails++; $display("FAIL lat_err_count: got %0d, want 1", ifa.err_count); end
    tests++; if (ifa.first_err_valid !== 1'b1) begin fails++; $display("FAIL lat_first_valid: got %b, want 1", ifa.first_err_valid); end
    tests++; if (ifa.first_err_info !== {3'd1, 4'hF, 4'h0, 5'b10000, 5'b00000}) begin fails++; $display("FAIL lat_first_info: got %h, want %h", ifa.first_err_info, {3'd1, 4'hF, 4'h0, 5'b10000, 5'b00000}); end
    tests++; if (ifa.vec_ready !== 1'b1 || ifa.done !== 1'b0) begin fails++; $display("FAIL lat_back_idle: ready %b done %b, want 1/0", ifa.vec_ready, ifa.done); end
    repeat (2) @(negedge clk);
    tests++; if (ifa.vec_count !== 12'd1 || ifa.drv_a !== 4'hF) begin fails++; $display("FAIL idle_hold: count %0d drv_a %h, want 1/f", ifa.vec_count, ifa.drv_a); end
    force_en = 1'b0;
  endtask

  task automatic test_first_err_hold();
    logic [3:0] iv;
    reset_a();
    for (int i = 0; i < 10; i++) begin
      iv   = 4'(i);
      flip = (i == 5 || i == 9) ? 5'b00001 : 5'b00000;
      send_a(iv[2:0], iv, 4'(15 - i));
      wait_idle_a();
      flip = 5'b00000;
      if (i == 5) begin
        tests++; if (ifa.err_count !== 12'd1 || ifa.first_err_valid !== 1'b1) begin fails++; $display("FAIL ferr_after_v5: err %0d valid %b, want 1/1", ifa.err_count, ifa.first_err_valid); end
      end
    end
    tests++; if (ifa.vec_count !== 12'd10) begin fails++; $display("FAIL ferr_vec_count: got %0d, want 10", ifa.vec_count); end
    tests++; if (ifa.err_count !== 12'd2) begin fails++; $display("FAIL ferr_err_count: got %0d, want 2", ifa.err_count); end
    tests++; if (ifa.first_err_info !== {3'd5, 4'd5, 4'd10, 5'd6, 5'd7}) begin fails++; $display("FAIL ferr_info_kept: got %h, want %h", ifa.first_err_info, {3'd5, 4'd5, 4'd10, 5'd6, 5'd7}); end
  endtask

  task automatic test_reset_abort();
    reset_a();
    for (int i = 0; i < 3; i++) begin
      send_a(3'd0, 4'(i), 4'd1);
      wait_idle_a();
    end
    tests++; if (ifa.vec_count !== 12'd3) begin fails++; $display("FAIL abort_pre_count: got %0d, want 3", ifa.vec_count); end
    send_a(3'd4, 4'h7, 4'h2);
    #1 rst_a = 1'b1;
    #1;
    tests++; if (ifa.vec_count !== 12'd0 || ifa.err_count !== 12'd0) begin fails++; $display("FAIL abort_counts: vec %0d err %0d, want 0/0", ifa.vec_count, ifa.err_count); end
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== 11'd0) begin fails++; $display("FAIL abort_drv: got %h, want 0", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}); end
    tests++; if (ifa.vec_ready !== 1'b1 || ifa.done !== 1'b0 || ifa.pass !== 1'b0) begin fails++; $display("FAIL abort_ready: ready %b done %b pass %b, want 1/0/0", ifa.vec_ready, ifa.done, ifa.pass); end
    @(negedge clk);
    rst_a         = 1'b0;
    ifa.vec_valid = 1'b1;
    ifa.vec_mode  = 3'd0;
    ifa.vec_a     = 4'h3;
    ifa.vec_b     = 4'h4;
    @(negedge clk);
    ifa.vec_valid = 1'b0;
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== {3'd0, 4'h3, 4'h4} || ifa.vec_ready !== 1'b0) begin fails++; $display("FAIL first_edge_hs: drv %h ready %b, want 034/0", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}, ifa.vec_ready); end
    wait_idle_a();
    tests++; if (ifa.vec_count !== 12'd1 || ifa.err_count !== 12'd0) begin fails++; $display("FAIL abort_next_count: vec %0d err %0d, want 1/0", ifa.vec_count, ifa.err_count); end
  endtask

  task automatic test_corners();
    logic [2:0] m;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin m = 3'd2; a = 4'h0; b = 4'h0; e = 5'b01111; end
        1:       begin m = 3'd6; a = 4'h0; b = 4'h3; e = 5'b01111; end
        default: begin m = 3'd7; a = 4'hA; b = 4'h3; e = 5'b11010; end
      endcase
      reset_a();
      force_en  = 1'b1;
      force_val = e;
      send_a(m, a, b);
      wait_idle_a();
      tests++; if (ifa.err_count !== 12'd0) begin fails++; $display("FAIL corner_match[%0d]: err %0d, want 0", k, ifa.err_count); end
      force_val = 5'd0;
      send_a(m, a, b);
      wait_idle_a();
      tests++; if (ifa.first_err_info !== {m, a, b, e, 5'd0}) begin fails++; $display("FAIL corner_capture[%0d]: got %h, want %h", k, ifa.first_err_info, {m, a, b, e, 5'd0}); end
      force_en = 1'b0;
    end
  endtask

  task automatic test_full_sweep();
    logic [10:0] v;
    reset_a();
    for (int i = 0; i < 2048; i++) begin
      v = 11'(i);
      send_a(v[10:8], v[7:4], v[3:0]);
    end
    repeat (3) @(negedge clk);
    tests++; if (ifa.done !== 1'b1 || ifa.pass !== 1'b1) begin fails++; $display("FAIL sweep_done_pass: done %b pass %b, want 1/1", ifa.done, ifa.pass); end
    tests++; if (ifa.vec_count !== 12'd2048) begin fails++; $display("FAIL sweep_vec_count: got %0d, want 2048", ifa.vec_count); end
    tests++; if (ifa.err_count !== 12'd0 || ifa.first_err_valid !== 1'b0) begin fails++; $display("FAIL sweep_errors: err %0d valid %b, want 0/0", ifa.err_count, ifa.first_err_valid); end
    tests++; if (ifa.vec_ready !== 1'b0) begin fails++; $display("FAIL sweep_ready: got %b, want 0", ifa.vec_ready); end
    ifa.vec_valid = 1'b1;
    ifa.vec_mode  = 3'd0;
    ifa.vec_a     = 4'h1;
    ifa.vec_b     = 4'h1;
    repeat (6) @(negedge clk);
    ifa.vec_valid = 1'b0;
    tests++; if (ifa.vec_count !== 12'd2048 || ifa.done !== 1'b1) begin fails++; $display("FAIL done_frozen: count %0d done %b, want 2048/1", ifa.vec_count, ifa.done); end
    tests++; if ({ifa.drv_mode, ifa.drv_a, ifa.drv_b} !== {3'd7, 4'hF, 4'hF}) begin fails++; $display("FAIL done_drv_hold: got %h, want %h", {ifa.drv_mode, ifa.drv_a, ifa.drv_b}, {3'd7, 4'hF, 4'hF}); end
  endtask

  task automatic test_back_to_back();
    int hs_cyc [8];
    int nhs;
    nhs = 0;
    for (int j = 0; j < 8; j++) hs_cyc[j] = -1;
    @(negedge clk);
    rst_b         = 1'b0;
    ifb.vec_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (ifb.vec_ready === 1'b1) begin
        if (nhs < 8) hs_cyc[nhs] = c;
        ifb.vec_mode = 3'(nhs);
        ifb.vec_a    = 4'(nhs + 3);
        ifb.vec_b    = 4'(nhs * 2);
        nhs++;
      end
      @(negedge clk);
    end
    ifb.vec_valid = 1'b0;
    tests++; if (nhs !== 4) begin fails++; $display("FAIL b2b_hs_count: got %0d, want 4", nhs); end
    tests++; if (hs_cyc[0] !== 0) begin fails++; $display("FAIL b2b_first_hs: cycle %0d, want 0", hs_cyc[0]); end
    for (int j = 1; j < 4; j++) begin
      tests++; if (hs_cyc[j] - hs_cyc[j-1] !== 3) begin fails++; $display("FAIL b2b_gap[%0d]: got %0d, want 3", j, hs_cyc[j] - hs_cyc[j-1]); end
    end
    tests++; if (ifb.done !== 1'b1 || ifb.pass !== 1'b1) begin fails++; $display("FAIL b2b_done_pass: done %b pass %b, want 1/1", ifb.done, ifb.pass); end
    tests++; if (ifb.vec_count !== 12'd4 || ifb.err_count !== 12'd0) begin fails++; $display("FAIL b2b_counts: vec %0d err %0d, want 4/0", ifb.vec_count, ifb.err_count); end
    tests++; if ({ifb.drv_mode, ifb.drv_a, ifb.drv_b} !== {3'd3, 4'd6, 4'd6} || ifb.vec_ready !== 1'b0) begin fails++; $display("FAIL b2b_frozen: drv %h ready %b, want 366/0", {ifb.drv_mode, ifb.drv_a, ifb.drv_b}, ifb.vec_ready); end
  endtask

  initial begin
    rst_a         = 1'b1;
    rst_b         = 1'b1;
    force_en      = 1'b0;
    force_val     = 5'd0;
    flip          = 5'd0;
    ifa.vec_valid = 1'b0;
    ifa.vec_mode  = 3'd0;
    ifa.vec_a     = 4'd0;
    ifa.vec_b     = 4'd0;
    ifb.vec_valid = 1'b0;
    ifb.vec_mode  = 3'd0;
    ifb.vec_a     = 4'd0;
    ifb.vec_b     = 4'd0;
    test_reset();
    test_latency();
    test_first_err_hold();
    test_reset_abort();
    test_corners();
    test_full_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
